axis_pair_split: RTL

Splits one packed AXI-Stream of operand pairs into two independent sign-extended operand streams, feeding the int1/int2 slave ports of the saturating adder. Each input word carries two signed samples, low half and high half. Each output has its own small FIFO, so the two consumers may stall independently. Unlike the adder ports, this block honours full tvalid/tready handshaking on every port.

---
 rtl/axis_pair_pkg.sv | 21 ++
 rtl/axis_fifo_sync.sv | 61 ++++++
 rtl/axis_pair_split.sv | 72 +++++++
 3 files changed

// File: rtl/axis_pair_pkg.sv
// Shared constants and helpers for the packed-pair stream splitter.
// Both halves of the input word are sign-extended to full bus width.
package axis_pair_pkg;

  localparam int AXIS_W = 32;
  localparam int HALF_W = 16;
  localparam int A_LSB  = 0;
  localparam int B_LSB  = 16;

  // Left-justify the sample, then shift it back arithmetically.
  function automatic logic [AXIS_W-1:0] sign_ext(
    input logic [HALF_W-1:0] s,
    input int unsigned       dw
  );
    logic signed [HALF_W-1:0] t;
    t = $signed(s << (HALF_W - dw));
    t = t >>> (HALF_W - dw);
    return AXIS_W'(t);
  endfunction

endpackage

// File: rtl/axis_fifo_sync.sv
// Single-clock FIFO with occupancy count and valid/ready read port.
// Pointers wrap naturally because DEPTH is a power of two.
module axis_fifo_sync
  import axis_pair_pkg::*;
#(
  parameter int W     = AXIS_W,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          rd_ready_i,
  output logic          rd_valid_o,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;
  logic          pop;

  assign rd_valid_o = (cnt_q != '0);
  assign dout_o     = mem_q[rptr_q];
  assign count_o    = cnt_q;
  assign pop        = rd_valid_o && rd_ready_i;
  assign push_ok    = push_i && (cnt_q < CW'(DEPTH));

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push_ok) mem_q[wptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/axis_pair_split.sv
// Splits a packed stream of signed sample pairs into two
// independently buffered, sign-extended output streams.
module axis_pair_split
  import axis_pair_pkg::*;
#(
  parameter int DW    = 14,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic              aclk,
  input  logic              rst_i,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [AXIS_W-1:0] s_axis_tdata,
  output logic              m_axis_int1_tvalid,
  input  logic              m_axis_int1_tready,
  output logic [AXIS_W-1:0] m_axis_int1_tdata,
  output logic              m_axis_int2_tvalid,
  input  logic              m_axis_int2_tready,
  output logic [AXIS_W-1:0] m_axis_int2_tdata,
  output logic [AXIS_W-1:0] pair_cnt
);

  logic [CW-1:0]     cnt1, cnt2;
  logic              accept;
  logic [AXIS_W-1:0] samp_a, samp_b;
  logic [AXIS_W-1:0] pair_cnt_q, pair_cnt_d;

  // Ready comes only from registered counts, never from tvalid.
  assign s_axis_tready = !rst_i
                      && (cnt1 < CW'(DEPTH))
                      && (cnt2 < CW'(DEPTH));
  assign accept = s_axis_tvalid && s_axis_tready;

  assign samp_a = sign_ext(s_axis_tdata[A_LSB +: HALF_W], DW);
  assign samp_b = sign_ext(s_axis_tdata[B_LSB +: HALF_W], DW);

  axis_fifo_sync #(.W(AXIS_W), .DEPTH(DEPTH)) u_f1 (
    .clk_i      (aclk),
    .rst_i      (rst_i),
    .push_i     (accept),
    .din_i      (samp_a),
    .rd_ready_i (m_axis_int1_tready),
    .rd_valid_o (m_axis_int1_tvalid),
    .dout_o     (m_axis_int1_tdata),
    .count_o    (cnt1)
  );

  axis_fifo_sync #(.W(AXIS_W), .DEPTH(DEPTH)) u_f2 (
    .clk_i      (aclk),
    .rst_i      (rst_i),
    .push_i     (accept),
    .din_i      (samp_b),
    .rd_ready_i (m_axis_int2_tready),
    .rd_valid_o (m_axis_int2_tvalid),
    .dout_o     (m_axis_int2_tdata),
    .count_o    (cnt2)
  );

  always_comb begin
    pair_cnt_d = pair_cnt_q;
    if (accept) pair_cnt_d = pair_cnt_q + 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (rst_i) pair_cnt_q <= '0;
    else       pair_cnt_q <= pair_cnt_d;
  end

  assign pair_cnt = pair_cnt_q;

endmodule
